// File: rtl/header_emitter.sv
// Frame header emitter.
// Captures the header fields on start, assembles a byte image of up to
// 18 bytes (magic, FHD, optional window descriptor, dictionary id, frame
// content size) and streams it two bytes per beat over a valid/ready
// interface. The earlier stream byte is placed in data_out[15:8].
//
// state | meaning
// IDLE  | waiting for start; out_valid low
// EMIT  | presenting beats until the out_last beat is accepted
// DONE  | one-cycle completion pulse on done
module header_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  fcs_flag,
  input  logic        single_segment,
  input  logic        checksum_flag,
  input  logic [1:0]  dict_id_flag,
  input  logic [7:0]  window_descriptor,
  input  logic [31:0] dictionary_id,
  input  logic [63:0] frame_content_size,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic        out_last,
  output logic [1:0]  out_nbytes,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hdr_len
);

  localparam int BUF_BYTES = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  hdr_buf [BUF_BYTES];
  logic [4:0]  ptr;

  logic [7:0]  cap_buf [BUF_BYTES];
  logic [4:0]  cap_len;
  logic [4:0]  cap_idx;
  logic [4:0]  dict_n;
  logic [4:0]  fcs_n;
  logic [63:0] fcs_val;
  logic [7:0]  fhd;

  logic [7:0]  beat_hi;
  logic [7:0]  beat_lo;
  logic        beat_has_lo;
  logic        beat_is_last;

  // Assemble the complete header image from the live inputs; only used on the start cycle.
  always_comb begin
    cap_buf = '{default: 8'h00};
    fhd     = {fcs_flag, single_segment, 1'b0, 1'b0, checksum_flag, dict_id_flag};
    case (dict_id_flag)
      2'b00:   dict_n = 5'd0;
      2'b01:   dict_n = 5'd1;
      2'b10:   dict_n = 5'd2;
      default: dict_n = 5'd4;
    endcase
    case (fcs_flag)
      2'b00:   fcs_n = single_segment ? 5'd1 : 5'd0;
      2'b01:   fcs_n = 5'd2;
      2'b10:   fcs_n = 5'd4;
      default: fcs_n = 5'd8;
    endcase
    // The two-byte size field is stored with a 256 offset.
    fcs_val = frame_content_size;
    if (fcs_flag == 2'b01) begin
      fcs_val = {48'h0, frame_content_size[15:0] - 16'd256};
    end
    cap_buf[0] = 8'h28;
    cap_buf[1] = 8'hB5;
    cap_buf[2] = 8'h2F;
    cap_buf[3] = 8'hFD;
    cap_buf[4] = fhd;
    cap_idx    = 5'd5;
    if (!single_segment) begin
      cap_buf[cap_idx] = window_descriptor;
      cap_idx          = cap_idx + 5'd1;
    end
    for (int i = 0; i < 4; i++) begin
      if (i < int'(dict_n)) begin
        cap_buf[cap_idx] = dictionary_id[8*i +: 8];
        cap_idx          = cap_idx + 5'd1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i < int'(fcs_n)) begin
        cap_buf[cap_idx] = fcs_val[8*i +: 8];
        cap_idx          = cap_idx + 5'd1;
      end
    end
    cap_len = 5'd5 + {4'd0, ~single_segment} + dict_n + fcs_n;
  end

  // Next beat to present, read from the captured image at the byte pointer.
  always_comb begin
    beat_hi      = 8'h00;
    beat_lo      = 8'h00;
    beat_has_lo  = 1'b0;
    if (ptr < 5'(BUF_BYTES)) begin
      beat_hi = hdr_buf[ptr];
    end
    if ((ptr + 5'd1) < hdr_len) begin
      beat_has_lo = 1'b1;
      beat_lo     = hdr_buf[ptr + 5'd1];
    end
    beat_is_last = (ptr + 5'd2) >= hdr_len;
  end

  // Sequencer with registered stream outputs; ptr always indexes the beat after the one on data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hdr_buf    <= '{default: 8'h00};
      ptr        <= 5'd0;
      hdr_len    <= 5'd0;
      out_valid  <= 1'b0;
      data_out   <= 16'h0000;
      out_last   <= 1'b0;
      out_nbytes <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= EMIT;
            hdr_buf    <= cap_buf;
            hdr_len    <= cap_len;
            ptr        <= 5'd2;
            out_valid  <= 1'b1;
            data_out   <= {cap_buf[0], cap_buf[1]};
            out_last   <= 1'b0;
            out_nbytes <= 2'd2;
            busy       <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state      <= DONE;
              out_valid  <= 1'b0;
              data_out   <= 16'h0000;
              out_last   <= 1'b0;
              out_nbytes <= 2'd0;
              done       <= 1'b1;
            end else begin
              data_out   <= {beat_hi, beat_lo};
              out_last   <= beat_is_last;
              out_nbytes <= beat_has_lo ? 2'd2 : 2'd1;
              ptr        <= ptr + 5'd2;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_header_emitter.sv
// Directed bench for header_emitter: header vectors, back-pressure,
// start while busy, done pulse and mid-frame reset.
module tb_header_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  fcs_flag;
  logic        single_segment;
  logic        checksum_flag;
  logic [1:0]  dict_id_flag;
  logic [7:0]  window_descriptor;
  logic [31:0] dictionary_id;
  logic [63:0] frame_content_size;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] data_out;
  logic        out_last;
  logic [1:0]  out_nbytes;
  logic        busy;
  logic        done;
  logic [4:0]  hdr_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_beats [8];
  int          exp_n;
  logic [1:0]  exp_nb;
  logic [4:0]  exp_len;

  logic [15:0] got_data [16];
  logic        got_last [16];
  logic [1:0]  got_nb   [16];
  int          got_n;
  bit          timed_out;
  logic [15:0] held     [4];
  logic        held_v   [4];

  header_emitter dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .fcs_flag           (fcs_flag),
    .single_segment     (single_segment),
    .checksum_flag      (checksum_flag),
    .dict_id_flag       (dict_id_flag),
    .window_descriptor  (window_descriptor),
    .dictionary_id      (dictionary_id),
    .frame_content_size (frame_content_size),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .data_out           (data_out),
    .out_last           (out_last),
    .out_nbytes         (out_nbytes),
    .busy               (busy),
    .done               (done),
    .hdr_len            (hdr_len)
  );

  always #5 clk = ~clk;

  task automatic set_vec(input int k);
    checksum_flag      = 1'b0;
    window_descriptor  = 8'h00;
    dictionary_id      = 32'h0;
    frame_content_size = 64'h0;
    case (k)
      0: begin
        single_segment = 1'b1; fcs_flag = 2'b00; dict_id_flag = 2'b00;
        frame_content_size = 64'h2A;
        exp_beats = '{16'h28B5, 16'h2FFD, 16'h202A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_n = 3; exp_nb = 2'd2; exp_len = 5'd6;
      end
      1: begin
        single_segment = 1'b0; window_descriptor = 8'h58; dict_id_flag = 2'b11;
        dictionary_id = 32'h11223344; fcs_flag = 2'b10;
        frame_content_size = 64'hAABBCCDD; checksum_flag = 1'b1;
        exp_beats = '{16'h28B5, 16'h2FFD, 16'h8758, 16'h4433, 16'h2211, 16'hDDCC, 16'hBBAA, 16'h0};
        exp_n = 7; exp_nb = 2'd2; exp_len = 5'd14;
      end
      2: begin
        single_segment = 1'b0; window_descriptor = 8'h40; dict_id_flag = 2'b01;
        dictionary_id = 32'h07; fcs_flag = 2'b00;
        exp_beats = '{16'h28B5, 16'h2FFD, 16'h0140, 16'h0700, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_n = 4; exp_nb = 2'd1; exp_len = 5'd7;
      end
      3: begin
        single_segment = 1'b1; fcs_flag = 2'b01; dict_id_flag = 2'b00;
        frame_content_size = 64'h0300;
        exp_beats = '{16'h28B5, 16'h2FFD, 16'h6000, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_n = 4; exp_nb = 2'd1; exp_len = 5'd7;
      end
      default: begin
        // Two-byte size below the 256 offset wraps: 0x0050 - 0x100 = 0xFF50.
        single_segment = 1'b0; window_descriptor = 8'h10; fcs_flag = 2'b01;
        dict_id_flag = 2'b00; frame_content_size = 64'h0050;
        exp_beats = '{16'h28B5, 16'h2FFD, 16'h4010, 16'h50FF, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_n = 4; exp_nb = 2'd2; exp_len = 5'd8;
      end
    endcase
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives out_ready and records accepted beats; optionally stalls one beat and pokes start meanwhile.
  task automatic collect(input int stall_beat, input int stall_len, input bit poke_start);
    int  cyc;
    int  stalled;
    bit  fin;
    got_n = 0; stalled = 0; fin = 0; cyc = 0; timed_out = 0;
    while (!fin) begin
      if (cyc > 60 || got_n >= 16) begin
        timed_out = 1; fin = 1;
      end else begin
        if (out_valid && got_n == stall_beat && stalled < stall_len) begin
          out_ready       = 1'b0;
          held[stalled]   = data_out;
          held_v[stalled] = out_valid;
          start           = poke_start;
          stalled++;
        end else begin
          out_ready = 1'b1;
          start     = 1'b0;
          if (out_valid) begin
            got_data[got_n] = data_out;
            got_last[got_n] = out_last;
            got_nb[got_n]   = out_nbytes;
            got_n++;
            if (out_last) fin = 1;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({out_valid, data_out, out_last, out_nbytes, busy, done, hdr_len} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b data=%h last=%b nb=%0d busy=%b done=%b len=%0d, want all zero",
               out_valid, data_out, out_last, out_nbytes, busy, done, hdr_len);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_frames();
    for (int k = 0; k < 5; k++) begin
      set_vec(k);
      kick();
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got valid=%b busy=%b, want 1 1", k, out_valid, busy);
      end
      // Inputs are don't-care after capture.
      frame_content_size = 64'hFFFF_FFFF_FFFF_FFFF;
      dictionary_id      = 32'hFFFF_FFFF;
      window_descriptor  = 8'hEE;
      collect(-1, 0, 1'b0);
      n_checks++;
      if (timed_out || got_n != exp_n) begin
        n_fail++;
        $display("FAIL vec%0d_beat_count: got %0d (timeout=%b), want %0d", k, got_n, timed_out, exp_n);
      end
      for (int b = 0; b < exp_n && b < got_n; b++) begin
        n_checks++;
        if (got_data[b] !== exp_beats[b] || got_last[b] !== (b == exp_n - 1) ||
            got_nb[b] !== ((b == exp_n - 1) ? exp_nb : 2'd2)) begin
          n_fail++;
          $display("FAIL vec%0d_beat%0d: got data=%h last=%b nb=%0d, want data=%h last=%b nb=%0d",
                   k, b, got_data[b], got_last[b], got_nb[b], exp_beats[b],
                   (b == exp_n - 1), (b == exp_n - 1) ? exp_nb : 2'd2);
        end
      end
      n_checks++;
      if (hdr_len !== exp_len || done !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_done: got len=%0d done=%b valid=%b, want len=%0d done=1 valid=0",
                 k, hdr_len, done, out_valid, exp_len);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_idle: got done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_back_pressure();
    set_vec(0);
    kick();
    // Change the configuration so a wrongly accepted start would alter the frame.
    single_segment = 1'b0; fcs_flag = 2'b11; dict_id_flag = 2'b11;
    collect(1, 3, 1'b1);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (held[s] !== 16'h2FFD || held_v[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got data=%h valid=%b, want 2ffd 1", s, held[s], held_v[s]);
      end
    end
    n_checks++;
    if (timed_out || got_n != 3 || got_data[0] !== 16'h28B5 || got_data[1] !== 16'h2FFD ||
        got_data[2] !== 16'h202A || got_last[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_frame: got n=%0d %h %h %h last=%b, want 3 28b5 2ffd 202a 1",
               got_n, got_data[0], got_data[1], got_data[2], got_last[2]);
    end
    n_checks++;
    if (done !== 1'b1 || hdr_len !== 5'd6) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b len=%0d, want 1 6", done, hdr_len);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: got busy=%b valid=%b done=%b, want 0 0 0", busy, out_valid, done);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_vec(1);
    kick();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || hdr_len !== 5'd0 || data_out !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b len=%0d data=%h, want 0 0 0 0000",
               out_valid, busy, hdr_len, data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    set_vec(3);
    kick();
    collect(-1, 0, 1'b0);
    n_checks++;
    if (timed_out || got_n != 4) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d (timeout=%b), want 4", got_n, timed_out);
    end
    for (int b = 0; b < 4 && b < got_n; b++) begin
      n_checks++;
      if (got_data[b] !== exp_beats[b]) begin
        n_fail++;
        $display("FAIL post_reset_beat%0d: got %h, want %h", b, got_data[b], exp_beats[b]);
      end
    end
    n_checks++;
    if (hdr_len !== 5'd7) begin
      n_fail++;
      $display("FAIL post_reset_len: got %0d, want 7", hdr_len);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    fcs_flag = 2'b00; single_segment = 1'b0; checksum_flag = 1'b0; dict_id_flag = 2'b00;
    window_descriptor = 8'h00; dictionary_id = 32'h0; frame_content_size = 64'h0;
    test_reset();
    test_frames();
    test_back_pressure();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/header_emitter.md
HEADER_EMITTER -- requirements
Module: header_emitter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  request to emit one frame header; sampled only in IDLE.
REQ-003 SHALL have ports: fcs_flag  in  2  Frame_Content_Size_flag; single_segment  in  1; checksum_flag  in  1; dict_id_flag  in  2.
REQ-004 SHALL have ports: window_descriptor  in  8; dictionary_id  in  32; frame_content_size  in  64.
REQ-005 SHALL have ports: out_ready  in  1  sink accepts beat.
REQ-006 SHALL have ports: out_valid  out  1; data_out  out  16  two header bytes, [15:8] earlier in stream, [7:0] later.
REQ-007 SHALL have ports: out_last  out  1  final beat; out_nbytes  out  2  valid bytes in beat (1 or 2).
REQ-008 SHALL have ports: busy  out  1  not IDLE; done  out  1  one-cycle pulse after last beat accepted; hdr_len  out  5  total header bytes.
REQ-009 Clock is clk; reset is reset, asynchronous, active-high.

Function
REQ-010 States IDLE, EMIT, DONE; IDLE->EMIT on start; EMIT->DONE when the out_last beat is accepted; DONE->IDLE unconditionally.
REQ-011 On start in IDLE, all inputs SHALL be captured into an 18-byte byte buffer and hdr_len latched; the inputs are don't-care afterwards.
REQ-012 Byte order: magic 0x28,0xB5,0x2F,0xFD; FHD; Window_Descriptor only if single_segment=0; Dictionary_ID; FCS.
REQ-013 FHD = {fcs_flag, single_segment, 1'b0, 1'b0, checksum_flag, dict_id_flag}.
REQ-014 Dictionary_ID byte count 0/1/2/4 for dict_id_flag 00/01/10/11, little-endian (bits [7:0] first).
REQ-015 FCS byte count: fcs_flag 00 -> single_segment ? 1 : 0; 01 -> 2; 10 -> 4; 11 -> 8; little-endian.
REQ-016 For fcs_flag=01 the emitted 16-bit value SHALL be (frame_content_size - 256) mod 2^16; otherwise the low field bits unmodified.
REQ-017 hdr_len = 5 + !single_segment + dict bytes + FCS bytes; range 6..18.
REQ-018 out_valid SHALL assert the cycle after start is accepted (latency 1) and remain high through EMIT.
REQ-019 A beat transfers when out_valid && out_ready; byte pointer advances by 2 per transfer; no advance otherwise.
REQ-020 data_out, out_last, out_nbytes SHALL be stable while out_valid && !out_ready.
REQ-021 Odd hdr_len: last beat has out_nbytes=1, byte in [15:8], [7:0]=0x00; even: out_nbytes=2.
REQ-022 out_nbytes SHALL be 2 on all non-last beats; out_last high only on the final beat.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 done SHALL pulse exactly one cycle, in DONE; out_valid low in DONE and IDLE; start in DONE is ignored.
REQ-025 busy = state != IDLE; hdr_len holds its value until the next accepted start.

Reset
REQ-026 reset SHALL force IDLE immediately, including mid-EMIT, discarding the in-flight header.
REQ-027 Reset values: out_valid=0, data_out=0, out_last=0, out_nbytes=0, busy=0, done=0, hdr_len=0, buffer and pointer=0.
REQ-028 First start after reset release SHALL emit a complete header from byte 0.

Verification
REQ-029 ss=1, fcs_flag=00, dict=00, cks=0, FCS=0x2A -> beats 0x28B5, 0x2FFD, 0x202A; last on beat 3, nbytes=2, hdr_len=6.
REQ-030 ss=0, wd=0x58, dict=11 id=0x11223344, fcs=10 FCS=0xAABBCCDD, cks=1 -> 0x28B5,0x2FFD,0x8758,0x4433,0x2211,0xDDCC,0xBBAA; hdr_len=14.
REQ-031 ss=0, wd=0x40, dict=01 id=0x07, fcs=00 -> 0x28B5,0x2FFD,0x0140,0x0700 with nbytes=1 on last; hdr_len=7.
REQ-032 ss=1, fcs=01, FCS=0x0300 -> 0x28B5,0x2FFD,0x6000,0x0200 (nbytes=1); hdr_len=7.
REQ-033 out_ready low 3 cycles on beat 2 -> 0x2FFD held with out_valid high; start pulsed mid-EMIT -> ignored; done pulses once.
REQ-034 reset asserted during beat 3 -> next cycle out_valid=0, busy=0; following start re-emits from 0x28B5.
